// File: rtl/alu_register_file_if.sv
// Operand register file bus: write controls, read selects and the two ALU operand outputs.
// The master drives controls and selects; the register file (slave) returns OutA/OutB.
interface alu_register_file_if;
    logic [31:0] data_in;
    logic [2:0]  fun_sel;
    logic [3:0]  reg_sel;
    logic [3:0]  scr_sel;
    logic [2:0]  out_a_sel;
    logic [2:0]  out_b_sel;
    logic [31:0] out_a;
    logic [31:0] out_b;

    modport master (
        output data_in, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
        input  out_a, out_b
    );

    modport slave (
        input  data_in, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
        output out_a, out_b
    );
endinterface

// File: rtl/alu_register_file.sv
// ALU operand register file: R1-R4 always present; S1-S4 present only when REGFILE_SCRATCH_EN
// is defined (otherwise selects 4-7 read 0 and scr_sel is ignored). Two combinational read ports.
module alu_register_file (
    input logic                  clk,
    input logic                  rst,
    alu_register_file_if.slave   bus
);

    function automatic logic [31:0] apply_op(
        input logic [31:0] q,
        input logic [2:0]  fun,
        input logic [31:0] d
    );
        logic [31:0] res;
        res = q;
        case (fun)
            3'b000:  res = q - 32'd1;
            3'b001:  res = q + 32'd1;
            3'b010:  res = d;
            3'b011:  res = 32'h0;
            3'b100:  res = {24'h0, d[7:0]};
            3'b101:  res = {q[31:16], d[15:0]};
            3'b110:  res = {q[23:0], d[7:0]};
            3'b111:  res = {{16{d[15]}}, d[15:0]};
            default: res = q;
        endcase
        return res;
    endfunction

    logic [31:0] gp_reg [4];
    logic [31:0] read_view [8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_reg <= '{default: 32'h0};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.reg_sel[k])
                    gp_reg[k] <= apply_op(gp_reg[k], bus.fun_sel, bus.data_in);
            end
        end
    end

`ifdef REGFILE_SCRATCH_EN
    logic [31:0] scr_reg [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scr_reg <= '{default: 32'h0};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.scr_sel[k])
                    scr_reg[k] <= apply_op(scr_reg[k], bus.fun_sel, bus.data_in);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            read_view[k]     = gp_reg[k];
            read_view[k + 4] = scr_reg[k];
        end
    end
`else
    // Scratch bank absent: keep scr_sel terminated so it does not float in lint.
    logic unused_scr_sel;
    assign unused_scr_sel = ^bus.scr_sel;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            read_view[k]     = gp_reg[k];
            read_view[k + 4] = 32'h0;
        end
    end
`endif

    assign bus.out_a = read_view[bus.out_a_sel];
    assign bus.out_b = read_view[bus.out_b_sel];

endmodule

// File: tb/tb_alu_register_file.sv
// Directed self-checking bench for alu_register_file; expectations follow REGFILE_SCRATCH_EN.
module tb_alu_register_file;

`ifdef REGFILE_SCRATCH_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_register_file_if bus ();

    alu_register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_sel = 4'b0000;
        bus.scr_sel = 4'b0000;
    endtask

    task automatic write_gp(input logic [3:0] sel, input logic [2:0] fun, input logic [31:0] d);
        bus.reg_sel = sel;
        bus.scr_sel = 4'b0000;
        bus.fun_sel = fun;
        bus.data_in = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        bus.out_a_sel = 3'd0;
        bus.out_b_sel = 3'd4;
        #2;
        n_checks++;
        if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_initial: out_a=%h out_b=%h expected 0/0", bus.out_a, bus.out_b);
        end
        @(negedge clk);
        rst = 1'b0;
        write_gp(4'b0001, 3'b010, 32'h12345678);
        n_checks++;
        if (bus.out_a !== 32'h12345678) begin
            n_fail++;
            $display("FAIL reset_preload: out_a=%h expected 12345678", bus.out_a);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: out_a=%h expected 0", bus.out_a);
        end
        // Reset across an edge with a pending write must still leave R1 at 0.
        bus.reg_sel = 4'b0001;
        bus.fun_sel = 3'b010;
        bus.data_in = 32'h55555555;
        tick();
        idle();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.out_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_override: out_a=%h expected 0", bus.out_a);
        end
    endtask

    task automatic test_load_dual();
        bus.fun_sel   = 3'b010;
        bus.data_in   = 32'hDEADBEEF;
        bus.reg_sel   = 4'b0001;
        bus.scr_sel   = 4'b0010;
        bus.out_a_sel = 3'd0;
        bus.out_b_sel = 3'd5;
        #1;
        n_checks++;
        if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL load_same_cycle: out_a=%h out_b=%h expected 0/0", bus.out_a, bus.out_b);
        end
        tick();
        idle();
        n_checks++;
        if (bus.out_a !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_out_a: out_a=%h expected deadbeef", bus.out_a);
        end
        n_checks++;
        if (bus.out_b !== (SCR ? 32'hDEADBEEF : 32'h0)) begin
            n_fail++;
            $display("FAIL load_out_b: out_b=%h expected %h", bus.out_b, SCR ? 32'hDEADBEEF : 32'h0);
        end
        bus.out_a_sel = 3'd1;
        bus.out_b_sel = 3'd4;
        #1;
        n_checks++;
        if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL load_untouched: r2=%h s1=%h expected 0/0", bus.out_a, bus.out_b);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        logic [2:0]  fun_seq [3];
        exp_seq = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        fun_seq = '{3'b000, 3'b001, 3'b001};
        bus.out_a_sel = 3'd1;
        bus.out_b_sel = 3'd1;
        for (int k = 0; k < 3; k++) begin
            write_gp(4'b0010, fun_seq[k], 32'hXXXXXXXX);
            n_checks++;
            if (bus.out_a !== exp_seq[k] || bus.out_b !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL wrap_step%0d: out_a=%h out_b=%h expected %h", k, bus.out_a, bus.out_b, exp_seq[k]);
            end
        end
    endtask

    task automatic test_partial();
        logic [2:0]  fun_seq [4];
        logic [31:0] din_seq [4];
        logic [31:0] exp_seq [4];
        fun_seq = '{3'b010, 3'b101, 3'b110, 3'b111};
        din_seq = '{32'hAABBCCDD, 32'h00001234, 32'h00000056, 32'h00008001};
        exp_seq = '{32'hAABBCCDD, 32'hAABB1234, 32'hBB123456, 32'hFFFF8001};
        bus.out_a_sel = 3'd2;
        for (int k = 0; k < 4; k++) begin
            write_gp(4'b0100, fun_seq[k], din_seq[k]);
            n_checks++;
            if (bus.out_a !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL partial_step%0d: out_a=%h expected %h", k, bus.out_a, exp_seq[k]);
            end
        end
    endtask

    task automatic test_multi_enable();
        logic [31:0] exp_v;
        bus.reg_sel = 4'b1111;
        bus.scr_sel = 4'b1111;
        bus.fun_sel = 3'b100;
        bus.data_in = 32'hFFFFFF7F;
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            bus.out_a_sel = 3'(k);
            bus.out_b_sel = 3'(k);
            #1;
            exp_v = (k < 4 || SCR) ? 32'h0000007F : 32'h0;
            n_checks++;
            if (bus.out_a !== exp_v || bus.out_b !== exp_v) begin
                n_fail++;
                $display("FAIL multi_load_sel%0d: out_a=%h out_b=%h expected %h", k, bus.out_a, bus.out_b, exp_v);
            end
        end
        write_gp(4'b0100, 3'b011, 32'hFFFFFFFF);
        for (int k = 0; k < 8; k++) begin
            bus.out_a_sel = 3'(k);
            #1;
            exp_v = (k == 2) ? 32'h0 : ((k < 4 || SCR) ? 32'h0000007F : 32'h0);
            n_checks++;
            if (bus.out_a !== exp_v) begin
                n_fail++;
                $display("FAIL multi_clear_sel%0d: out_a=%h expected %h", k, bus.out_a, exp_v);
            end
        end
    endtask

    task automatic test_config();
        logic [31:0] exp_v;
        bus.reg_sel = 4'b0000;
        bus.scr_sel = 4'b1111;
        bus.fun_sel = 3'b010;
        bus.data_in = 32'h00000001;
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            bus.out_b_sel = 3'(k);
            #1;
            if (k < 4)
                exp_v = (k == 2) ? 32'h0 : 32'h0000007F;
            else
                exp_v = SCR ? 32'h00000001 : 32'h0;
            n_checks++;
            if (bus.out_b !== exp_v) begin
                n_fail++;
                $display("FAIL config_sel%0d: out_b=%h expected %h", k, bus.out_b, exp_v);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.data_in = 32'h0;
        bus.fun_sel = 3'b000;
        bus.reg_sel = 4'b0000;
        bus.scr_sel = 4'b0000;
        bus.out_a_sel = 3'd0;
        bus.out_b_sel = 3'd0;
        test_reset();
        test_load_dual();
        test_wrap();
        test_partial();
        test_multi_enable();
        test_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
